// File: rtl/vc_vr_pkg.sv
// vc_vr_pkg: shared helpers and types for the valid/credit to valid/ready mux converter.
package vc_vr_pkg;
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
  localparam int CREDIT_NUM_DEF = 2;
  typedef logic [$clog2(CREDIT_NUM_DEF+1)-1:0] credit_cnt_t;
endpackage

// File: rtl/vc_vr_mux_converter_if.sv
// vc_vr_mux_converter_if: upstream credit channels plus merged downstream valid/ready port.
interface vc_vr_mux_converter_if #(
  parameter int DATA_WIDTH = 8,
  parameter int CH_NUM     = 4
);
  localparam int CH_IDX_W = vc_vr_pkg::clog2_min1(CH_NUM);
  logic [CH_NUM*DATA_WIDTH-1:0] s_data_i;
  logic [CH_NUM-1:0]            s_valid_i;
  logic [CH_NUM-1:0]            s_credit_o;
  logic [CH_NUM-1:0]            s_err_o;
  logic                         m_ready_i;
  logic [DATA_WIDTH-1:0]        m_data_o;
  logic [CH_IDX_W-1:0]          m_chan_o;
  logic                         m_valid_o;
  modport master (output s_data_i, s_valid_i, m_ready_i,
                  input  s_credit_o, s_err_o, m_data_o, m_chan_o, m_valid_o);
  modport slave  (input  s_data_i, s_valid_i, m_ready_i,
                  output s_credit_o, s_err_o, m_data_o, m_chan_o, m_valid_o);
endinterface

// File: rtl/vc_vr_chan_fifo.sv
// vc_vr_chan_fifo: per-channel skid buffer with credit return pulse and sticky overflow flag.
module vc_vr_chan_fifo import vc_vr_pkg::*; #(
  parameter int DW    = 8,
  parameter int DEPTH = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [DW-1:0] data,
  input  logic          pop,
  output logic [DW-1:0] head,
  output logic          nonempty,
  output logic          credit_o,
  output logic          err_o
);
  localparam int PW = clog2_min1(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  logic [DW-1:0] mem [DEPTH];
  logic [PW-1:0] rd, wr;
  logic [CW-1:0] cnt;
  logic          full, wr_en;
  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH-1)) ? '0 : p + 1'b1;
  endfunction
  assign full     = cnt == CW'(DEPTH);
  assign wr_en    = push && (!full || pop);
  assign head     = mem[rd];
  assign nonempty = cnt != '0;
  always_ff @(posedge clk)
    if (wr_en) mem[wr] <= data;
  // a push into a full buffer only survives if the head leaves in the same cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd       <= '0;
      wr       <= '0;
      cnt      <= '0;
      credit_o <= 1'b0;
      err_o    <= 1'b0;
    end else begin
      if (wr_en) wr <= inc(wr);
      if (pop) rd <= inc(rd);
      cnt      <= cnt + CW'(wr_en) - CW'(pop);
      credit_o <= pop;
      err_o    <= err_o | (push && !wr_en);
    end
  end
endmodule

// File: rtl/vc_vr_mux_converter.sv
// vc_vr_mux_converter: merges CH_NUM valid/credit channels onto one valid/ready port
// with round-robin arbitration that freezes its grant under backpressure.
module vc_vr_mux_converter import vc_vr_pkg::*; #(
  parameter int DATA_WIDTH = 8,
  parameter int CREDIT_NUM = 2,
  parameter int CH_NUM     = 4
) (
  input logic                  clk,
  input logic                  rst_n,
  vc_vr_mux_converter_if.slave bus
);
  localparam int IW = clog2_min1(CH_NUM);
  logic [DATA_WIDTH-1:0] head [CH_NUM];
  logic [CH_NUM-1:0]     ne, pop, cred, err;
  logic [IW-1:0]         ptr, grant, sel, lock_ch, last_chan;
  logic [DATA_WIDTH-1:0] last_data;
  logic                  locked, found, xfer;
  for (genvar c = 0; c < CH_NUM; c++) begin : g_ch
    vc_vr_chan_fifo #(.DW(DATA_WIDTH), .DEPTH(CREDIT_NUM)) u_fifo (
      .clk(clk), .rst_n(rst_n),
      .push(bus.s_valid_i[c]), .data(bus.s_data_i[c*DATA_WIDTH +: DATA_WIDTH]),
      .pop(pop[c]), .head(head[c]), .nonempty(ne[c]),
      .credit_o(cred[c]), .err_o(err[c])
    );
  end
  always_comb begin
    grant = ptr;
    found = 1'b0;
    for (int i = 0; i < CH_NUM; i++)
      if (!found && ne[(int'(ptr) + i) % CH_NUM]) begin
        grant = IW'((int'(ptr) + i) % CH_NUM);
        found = 1'b1;
      end
  end
  assign sel            = locked ? lock_ch : grant;
  assign bus.m_valid_o  = |ne;
  assign xfer           = bus.m_valid_o && bus.m_ready_i;
  assign pop            = xfer ? (CH_NUM'(1) << sel) : '0;
  assign bus.m_data_o   = bus.m_valid_o ? head[sel] : last_data;
  assign bus.m_chan_o   = bus.m_valid_o ? sel : last_chan;
  assign bus.s_credit_o = cred;
  assign bus.s_err_o    = err;
  // an offered but unaccepted beat pins the grant until its handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr       <= '0;
      locked    <= 1'b0;
      lock_ch   <= '0;
      last_data <= '0;
      last_chan <= '0;
    end else begin
      locked  <= bus.m_valid_o && !bus.m_ready_i;
      lock_ch <= sel;
      if (bus.m_valid_o) begin
        last_data <= head[sel];
        last_chan <= sel;
      end
      if (xfer) ptr <= (sel == IW'(CH_NUM-1)) ? '0 : sel + 1'b1;
    end
  end
endmodule

// File: tb/tb_vc_vr_mux_converter.sv
// tb_vc_vr_mux_converter: directed plus randomized checks against a queue-based channel model.
module tb_vc_vr_mux_converter;
  localparam int DW = 8, CN = 2, CH = 4;
  logic clk = 1'b0, rst_n = 1'b1, run = 1'b0;
  always #5 clk = ~clk;
  vc_vr_mux_converter_if #(.DATA_WIDTH(DW), .CH_NUM(CH)) bus();
  vc_vr_mux_converter #(.DATA_WIDTH(DW), .CREDIT_NUM(CN), .CH_NUM(CH)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );
  int total = 0, bad = 0;
  logic [DW-1:0] q [CH][$];
  int ptr = 0, lk = 0, lk_ch = 0, last_c = 0;
  logic [DW-1:0] last_d = '0;
  logic [CH-1:0] e_cred = '0, e_err = '0;
  int cr [CH];

  function automatic int pick();
    if (lk != 0) return lk_ch;
    for (int i = 0; i < CH; i++)
      if (q[(ptr + i) % CH].size() > 0) return (ptr + i) % CH;
    return -1;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: per-channel queues, round-robin pointer, frozen grant while stalled
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < CH; c++) q[c].delete();
      ptr = 0; lk = 0; lk_ch = 0; last_c = 0; last_d = '0; e_cred = '0; e_err = '0;
    end else begin
      int ch;
      logic [CH-1:0] pops;
      ch = pick();
      pops = '0;
      if (ch >= 0) begin
        last_d = q[ch][0];
        last_c = ch;
      end
      if (ch >= 0 && bus.m_ready_i) begin
        void'(q[ch].pop_front());
        pops[ch] = 1'b1;
        ptr = (ch + 1) % CH;
        lk = 0;
      end else begin
        lk = (ch >= 0) ? 1 : 0;
        lk_ch = ch;
      end
      for (int c = 0; c < CH; c++)
        if (bus.s_valid_i[c]) begin
          if (q[c].size() < CN) q[c].push_back(bus.s_data_i[c*DW +: DW]);
          else e_err[c] = 1'b1;
        end
      e_cred = pops;
    end
  end

  always @(negedge clk) begin
    if (run && rst_n) begin
      int ch;
      ch = pick();
      chk("m_valid", {31'b0, bus.m_valid_o}, (ch >= 0) ? 32'd1 : 32'd0);
      if (ch >= 0) begin
        chk("m_data", {24'b0, bus.m_data_o}, {24'b0, q[ch][0]});
        chk("m_chan", {30'b0, bus.m_chan_o}, ch);
      end else begin
        chk("m_data_hold", {24'b0, bus.m_data_o}, {24'b0, last_d});
        chk("m_chan_hold", {30'b0, bus.m_chan_o}, last_c);
      end
      chk("s_credit", {28'b0, bus.s_credit_o}, {28'b0, e_cred});
      chk("s_err", {28'b0, bus.s_err_o}, {28'b0, e_err});
    end
  end

  task automatic cyc(input logic [CH-1:0] v, input logic [CH*DW-1:0] d, input logic r);
    @(posedge clk); #1;
    bus.s_valid_i = v; bus.s_data_i = d; bus.m_ready_i = r;
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0; bus.s_valid_i = '0; bus.s_data_i = '0; bus.m_ready_i = 1'b0;
    @(negedge clk);
    chk("rst_valid", {31'b0, bus.m_valid_o}, 0);
    chk("rst_data", {24'b0, bus.m_data_o}, 0);
    chk("rst_chan", {30'b0, bus.m_chan_o}, 0);
    chk("rst_credit", {28'b0, bus.s_credit_o}, 0);
    chk("rst_err", {28'b0, bus.s_err_o}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    run = 1'b1;
    for (int c = 0; c < CH; c++) cr[c] = CN;
  endtask

  initial begin
    bus.s_valid_i = '0; bus.s_data_i = '0; bus.m_ready_i = 1'b0;
    // single beat on ch0, held under backpressure
    do_reset();
    cyc(4'b0001, 32'h0000_00EE, 1'b0);
    chk("sb_push_cycle", {31'b0, bus.m_valid_o}, 0);
    repeat (5) begin
      cyc('0, '0, 1'b0);
      chk("sb_valid", {31'b0, bus.m_valid_o}, 1);
      chk("sb_data", {24'b0, bus.m_data_o}, 32'hEE);
      chk("sb_chan", {30'b0, bus.m_chan_o}, 0);
    end
    cyc('0, '0, 1'b1);
    chk("sb_credit_none", {28'b0, bus.s_credit_o}, 0);
    cyc('0, '0, 1'b0);
    chk("sb_credit", {28'b0, bus.s_credit_o}, 32'h1);
    chk("sb_empty", {31'b0, bus.m_valid_o}, 0);
    chk("sb_hold", {24'b0, bus.m_data_o}, 32'hEE);
    cyc('0, '0, 1'b0);
    chk("sb_credit_once", {28'b0, bus.s_credit_o}, 0);
    // fairness across all channels
    do_reset();
    cyc(4'b1111, 32'hA3A2_A1A0, 1'b1);
    for (int i = 0; i < CH; i++) begin
      cyc('0, '0, 1'b1);
      chk("rr_chan", {30'b0, bus.m_chan_o}, i);
      chk("rr_data", {24'b0, bus.m_data_o}, 32'hA0 + i);
      chk("rr_credit", {28'b0, bus.s_credit_o}, (i == 0) ? 0 : (1 << (i - 1)));
    end
    cyc('0, '0, 1'b1);
    chk("rr_last_credit", {28'b0, bus.s_credit_o}, 32'h8);
    // grant stays frozen while stalled
    do_reset();
    cyc(4'b0100, 32'h0022_0000, 1'b0);
    cyc(4'b0001, 32'h0000_0000, 1'b0);
    chk("lk_chan0", {30'b0, bus.m_chan_o}, 2);
    repeat (2) begin
      cyc('0, '0, 1'b0);
      chk("lk_chan", {30'b0, bus.m_chan_o}, 2);
      chk("lk_data", {24'b0, bus.m_data_o}, 32'h22);
    end
    cyc('0, '0, 1'b1);
    chk("lk_hs_chan", {30'b0, bus.m_chan_o}, 2);
    cyc('0, '0, 1'b0);
    chk("lk_next_chan", {30'b0, bus.m_chan_o}, 0);
    chk("lk_next_data", {24'b0, bus.m_data_o}, 0);
    // overflow on ch1
    do_reset();
    cyc(4'b0010, 32'h0000_1100, 1'b0);
    cyc(4'b0010, 32'h0000_1200, 1'b0);
    cyc(4'b0010, 32'h0000_1300, 1'b0);
    chk("ov_err_pre", {28'b0, bus.s_err_o}, 0);
    cyc('0, '0, 1'b0);
    chk("ov_err", {28'b0, bus.s_err_o}, 32'h2);
    cyc('0, '0, 1'b1);
    chk("ov_d0", {24'b0, bus.m_data_o}, 32'h11);
    cyc('0, '0, 1'b1);
    chk("ov_d1", {24'b0, bus.m_data_o}, 32'h12);
    cyc('0, '0, 1'b1);
    chk("ov_drained", {31'b0, bus.m_valid_o}, 0);
    chk("ov_sticky", {28'b0, bus.s_err_o}, 32'h2);
    // push and pop together on a full buffer
    do_reset();
    cyc(4'b1000, 32'h3100_0000, 1'b0);
    cyc(4'b1000, 32'h3200_0000, 1'b0);
    cyc(4'b1000, 32'h3300_0000, 1'b1);
    chk("fp_d0", {24'b0, bus.m_data_o}, 32'h31);
    cyc('0, '0, 1'b1);
    chk("fp_d1", {24'b0, bus.m_data_o}, 32'h32);
    chk("fp_noerr", {28'b0, bus.s_err_o}, 0);
    chk("fp_cred1", {28'b0, bus.s_credit_o}, 32'h8);
    cyc('0, '0, 1'b1);
    chk("fp_d2", {24'b0, bus.m_data_o}, 32'h33);
    cyc('0, '0, 1'b0);
    chk("fp_cred3", {28'b0, bus.s_credit_o}, 32'h8);
    cyc('0, '0, 1'b0);
    chk("fp_cred_end", {28'b0, bus.s_credit_o}, 0);
    // reset while data is buffered
    do_reset();
    cyc(4'b0011, 32'h0000_5101, 1'b0);
    cyc(4'b0011, 32'h0000_5202, 1'b0);
    cyc(4'b0010, 32'h0000_5300, 1'b0);
    cyc('0, '0, 1'b0);
    chk("mr_err_before", {28'b0, bus.s_err_o}, 32'h2);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("mr_valid", {31'b0, bus.m_valid_o}, 0);
    chk("mr_credit", {28'b0, bus.s_credit_o}, 0);
    chk("mr_err", {28'b0, bus.s_err_o}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int c = 0; c < CH; c++) cr[c] = CN;
    repeat (3) begin
      cyc('0, '0, 1'b1);
      chk("mr_no_credit", {28'b0, bus.s_credit_o}, 0);
      chk("mr_empty", {31'b0, bus.m_valid_o}, 0);
    end
    // randomized traffic, mostly credit-respecting with occasional overruns
    for (int n = 0; n < 3000; n++) begin
      logic [CH-1:0] v;
      logic [CH*DW-1:0] d;
      if (n == 1500) do_reset();
      for (int c = 0; c < CH; c++) begin
        v[c] = ((cr[c] > 0) && ($urandom_range(0, 2) != 0)) || ($urandom_range(0, 49) == 0);
        if (v[c] && cr[c] > 0) cr[c]--;
        d[c*DW +: DW] = DW'($urandom);
      end
      cyc(v, d, $urandom_range(0, 9) < 7);
      for (int c = 0; c < CH; c++) if (bus.s_credit_o[c]) cr[c]++;
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/vc_vr_mux_converter.md
Name: vc_vr_mux_converter

Overview:
- Multi-channel successor to the single-channel valid/credit to valid/ready converter.
- Terminates CH_NUM independent valid/credit upstream channels, each with its own CREDIT_NUM-deep skid buffer.
- Merges the channels onto one valid/ready downstream port using a round-robin arbiter and tags each beat with its source channel.
- Sits between credit-based link receivers and ready-based internal datapaths.

Parameters:
- DATA_WIDTH, 8: payload width per channel.
- CREDIT_NUM, 2: credits per channel; equals the per-channel buffer depth (>=1).
- CH_NUM, 4: number of upstream channels (>=1).
- CH_IDX_W, $clog2(CH_NUM) (min 1): width of the channel tag. Derived, not overridable.

Ports:
- clk, in, 1: clock.
- rst_n, in, 1: reset. Asynchronous assert, active-low.
- s_data_i, in, CH_NUM*DATA_WIDTH: per-channel payload; channel c occupies bits [c*DATA_WIDTH +: DATA_WIDTH].
- s_valid_i, in, CH_NUM: per-channel write strobe, one beat per cycle when high.
- s_credit_o, out, CH_NUM: per-channel credit return pulse, one credit per cycle high.
- s_err_o, out, CH_NUM: sticky overflow flag per channel.
- m_ready_i, in, 1: downstream ready.
- m_data_o, out, DATA_WIDTH: payload of the granted channel.
- m_chan_o, out, CH_IDX_W: index of the granted channel.
- m_valid_o, out, 1: downstream valid.

Behaviour:
- Reset: one clock; reset is asynchronous and active-low (rst_n). All buffers empty, RR pointer = 0, lock cleared.
- Reset output values: s_credit_o = 0, s_err_o = 0, m_valid_o = 0, m_data_o = 0, m_chan_o = 0.
- Credit protocol:
  - The sender holds CREDIT_NUM credits per channel implicitly after reset; the block never pulses credits at reset.
  - The sender spends one credit per s_valid_i beat.
  - Each pop from channel c's buffer produces exactly one registered s_credit_o[c] pulse in the cycle after the pop.
- Write: s_valid_i[c] at edge k writes s_data_i slice c into buffer c. Minimum latency: m_valid_o may be high in cycle k+1 with that data.
- Overflow: s_valid_i[c] while buffer c is full and not popping in the same cycle.
  - The beat is dropped and s_err_o[c] is set.
  - s_err_o[c] clears only on reset.
  - Simultaneous push and pop on a full buffer is legal: no error, occupancy unchanged.
- Arbiter, stateless between transfers:
  - Grant = first non-empty channel searching from ptr upward, wrapping modulo CH_NUM.
  - m_valid_o = |nonempty. m_data_o and m_chan_o come from the granted head. When m_valid_o = 0, m_data_o and m_chan_o hold their last values.
- Lock: while m_valid_o && !m_ready_i, the grant is frozen. m_chan_o and m_data_o must not change even if a higher-priority channel becomes non-empty.
- Transfer: m_valid_o && m_ready_i pops the granted buffer, sets ptr = grant+1 (mod CH_NUM) and releases the lock.
- Back-to-back: a full-rate stream with m_ready_i held high transfers one beat per cycle. A single active channel sustains 1 beat/cycle when CREDIT_NUM >= 2. With CREDIT_NUM = 1 a channel sustains 1 beat per 2 cycles, limited by credit round trip.
- Per-channel FIFO:
  - Read/write pointers wrap at CREDIT_NUM, so non-power-of-2 depths are supported.
  - Occupancy counter width is $clog2(CREDIT_NUM+1).
  - Data order within a channel is preserved.
- Reset mid-operation: buffered data is discarded. No credits are returned for discarded beats; the sender resets its credit count on the same reset.
- CH_NUM = 1: degenerates to the single-channel converter, with m_chan_o tied to 0.

Decomposition:
- Package vc_vr_pkg: function for safe clog2 (min 1); typedef for the credit counter width.
- Sub-module vc_vr_chan_fifo:
  - One per channel, generated CH_NUM times.
  - Contains the buffer, pointers, occupancy, credit-pulse register and error flag.
  - Interface: push, data, pop, head data, nonempty, full, credit_o, err_o.
- Top level contains the generate loop, round-robin arbiter, lock register and output mux.

Test Plan:
- Single beat, channel 0: after reset, s_valid_i = 4'b0001 with data 0xEE, m_ready_i = 0. Expect m_valid_o = 1, m_data_o = 0xEE, m_chan_o = 0, stable for 5 cycles. Raise m_ready_i: one transfer occurs, then s_credit_o[0] pulses exactly 1 cycle later.
- Fairness: all 4 channels each push 0xA0+c in the same cycle, m_ready_i = 1. Expect output order ch0, ch1, ch2, ch3 with data 0xA0 through 0xA3 on consecutive cycles, then 4 credit pulses, one per channel.
- Lock under backpressure: ch2 holds 0x22 with m_ready_i = 0, then ch0 pushes 0x00. Expect m_chan_o to stay 2 with data 0x22 until the handshake, then ch0/0x00 next.
- Overflow: CREDIT_NUM = 2, ch1 pushes 0x11, 0x12, 0x13 with m_ready_i = 0. Expect s_err_o[1] = 1 from the third beat. Output later yields only 0x11 then 0x12, and s_err_o[1] stays 1.
- Full push/pop: ch3 full (2 entries), m_ready_i = 1 while ch3 pushes 0x33. Expect no error, output order preserved, exactly one credit pulse for that cycle.
- Reset mid-stream: ch0 holds 2 entries and rst_n drops for 1 cycle. Expect m_valid_o = 0, s_credit_o = 0 and s_err_o = 0 immediately, with no credit pulses after release.
